// File: rtl/traffic_pkg.sv
// traffic_pkg: fault codes and monitor state encodings shared by the conflict monitor.
// Rev 1.0
`default_nettype none

package traffic_pkg;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_CONFLICT  = 3'd1;
  localparam logic [2:0] FC_MULTI     = 3'd2;
  localparam logic [2:0] FC_DARK      = 3'd3;
  localparam logic [2:0] FC_SHORT_YEL = 3'd4;

  typedef enum logic [1:0] {
    MONITOR     = 2'd0,
    FAULT_FLASH = 2'd1,
    CLEARING    = 2'd2
  } state_t;

  // Lamp vector order used throughout: {g_a, y_a, r_a, g_b, y_b, r_b}
  localparam logic [5:0] LAMPS_SAFE = 6'b001_001;

endpackage

`default_nettype wire

// File: rtl/traffic_dir_checker.sv
// traffic_dir_checker: per-direction multi-lamp, dark-run and short-yellow detection.
// Rev 1.0
`default_nettype none

module traffic_dir_checker
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int MAX_DARK   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic r,
  input  logic y,
  input  logic g,
  output logic multi,
  output logic dark,
  output logic short_yel
);

  localparam int DARK_W = $clog2(MAX_DARK + 1);
  localparam int YEL_W  = $clog2(MIN_YELLOW + 1);

  logic [DARK_W-1:0] dark_cnt_q, dark_cnt_d;
  logic [YEL_W-1:0]  yel_cnt_q, yel_cnt_d;
  logic [2:0]        prev_q, prev_d;  // {g, y, r} of the previous cycle
  logic              no_lamp;

  always_comb begin
    no_lamp    = !(r || y || g);
    multi      = (r && y) || (r && g) || (y && g);
    // Counter holds the dark cycles before this one, so this is run length MAX_DARK+1.
    dark       = no_lamp && (dark_cnt_q >= DARK_W'(MAX_DARK));
    short_yel  = (prev_q[1] && !y && (yel_cnt_q < YEL_W'(MIN_YELLOW)))
              || (prev_q[2] && !g && r && !prev_q[0] && !y);

    dark_cnt_d = '0;
    yel_cnt_d  = '0;
    prev_d     = '0;
    if (!clr) begin
      prev_d = {g, y, r};
      if (no_lamp) begin
        dark_cnt_d = (dark_cnt_q == DARK_W'(MAX_DARK)) ? dark_cnt_q : dark_cnt_q + 1'b1;
      end
      if (y) begin
        yel_cnt_d = (yel_cnt_q == YEL_W'(MIN_YELLOW)) ? yel_cnt_q : yel_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dark_cnt_q <= '0;
      yel_cnt_q  <= '0;
      prev_q     <= '0;
    end else begin
      dark_cnt_q <= dark_cnt_d;
      yel_cnt_q  <= yel_cnt_d;
      prev_q     <= prev_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: registered lamp pass-through with fault latch and all-red flash.
// Rev 1.0
`default_nettype none

module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int MAX_DARK   = 2,
  parameter int FLASH_HALF = 50,
  parameter int CLR_HOLD   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       green_a,
  input  logic       yellow_a,
  input  logic       red_a,
  input  logic       green_b,
  input  logic       yellow_b,
  input  logic       red_b,
  input  logic       clear_fault,
  output logic       lamp_g_a,
  output logic       lamp_y_a,
  output logic       lamp_r_a,
  output logic       lamp_g_b,
  output logic       lamp_y_b,
  output logic       lamp_r_b,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int FLASH_W = $clog2(FLASH_HALF + 1);
  localparam int HOLD_W  = $clog2(CLR_HOLD + 1);

  state_t             state_q, state_d;
  logic [5:0]         lamps_q, lamps_d;
  logic [2:0]         code_q, code_d;
  logic               phase_q, phase_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

  logic       multi_a, dark_a, short_a;
  logic       multi_b, dark_b, short_b;
  logic       dir_clr;
  logic       conflict;
  logic       all_red;
  logic [2:0] code_det;
  logic [5:0] lamps_in;

  // History is held clear while faulted so the return to MONITOR starts fresh.
  assign dir_clr = (state_q != MONITOR);

  traffic_dir_checker #(.MIN_YELLOW(MIN_YELLOW), .MAX_DARK(MAX_DARK)) u_chk_a (
    .clk(clk), .reset(reset), .clr(dir_clr),
    .r(red_a), .y(yellow_a), .g(green_a),
    .multi(multi_a), .dark(dark_a), .short_yel(short_a)
  );

  traffic_dir_checker #(.MIN_YELLOW(MIN_YELLOW), .MAX_DARK(MAX_DARK)) u_chk_b (
    .clk(clk), .reset(reset), .clr(dir_clr),
    .r(red_b), .y(yellow_b), .g(green_b),
    .multi(multi_b), .dark(dark_b), .short_yel(short_b)
  );

  always_comb begin
    lamps_in = {green_a, yellow_a, red_a, green_b, yellow_b, red_b};
    conflict = (green_a || yellow_a) && (green_b || yellow_b);
    all_red  = red_a && red_b && !(green_a || yellow_a || green_b || yellow_b);

    if (conflict)                code_det = FC_CONFLICT;
    else if (multi_a || multi_b) code_det = FC_MULTI;
    else if (dark_a || dark_b)   code_det = FC_DARK;
    else if (short_a || short_b) code_det = FC_SHORT_YEL;
    else                         code_det = FC_NONE;

    state_d     = state_q;
    lamps_d     = lamps_q;
    code_d      = code_q;
    phase_d     = phase_q;
    flash_cnt_d = '0;
    hold_cnt_d  = '0;

    case (state_q)
      MONITOR: begin
        if (code_det != FC_NONE) begin
          state_d = FAULT_FLASH;
          code_d  = code_det;
          lamps_d = LAMPS_SAFE;
          phase_d = 1'b1;
        end else begin
          lamps_d = lamps_in;
        end
      end
      FAULT_FLASH: begin
        if (flash_cnt_q == FLASH_W'(FLASH_HALF - 1)) begin
          phase_d = !phase_q;
        end else begin
          flash_cnt_d = flash_cnt_q + 1'b1;
        end
        lamps_d = {2'b00, phase_d, 2'b00, phase_d};
        if (clear_fault) begin
          if (hold_cnt_q == HOLD_W'(CLR_HOLD - 1)) begin
            state_d = CLEARING;
            lamps_d = LAMPS_SAFE;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      CLEARING: begin
        lamps_d = LAMPS_SAFE;
        if (all_red) begin
          state_d = MONITOR;
          code_d  = FC_NONE;
          lamps_d = lamps_in;
        end
      end
      default: begin
        state_d = MONITOR;
        lamps_d = LAMPS_SAFE;
        code_d  = FC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= MONITOR;
      lamps_q     <= LAMPS_SAFE;
      code_q      <= FC_NONE;
      phase_q     <= 1'b1;
      flash_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      lamps_q     <= lamps_d;
      code_q      <= code_d;
      phase_q     <= phase_d;
      flash_cnt_q <= flash_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign {lamp_g_a, lamp_y_a, lamp_r_a, lamp_g_b, lamp_y_b, lamp_r_b} = lamps_q;
  assign fault      = (state_q != MONITOR);
  assign fault_code = code_q;

endmodule

`default_nettype wire
